pipe_stage_hs: RTL and testbench
================================

Name: pipe_stage_hs

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one generic control bundle and one generic data bundle.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure propagates without a combinational ready path.
- Adds synchronous flush (bubble insertion) for branch/hazard recovery; sits between any two pipeline stages.

Parameters:
- DATA_W, 64: width of the data bundle (operands, immediate, register addresses, funct).
- CTRL_W, 8: width of the control bundle (aluOp, aluSrc, memRead, memWrite, memToReg, regWrite, ...).
- CTRL_BUBBLE, {CTRL_W{1'b0}}: control value presented when the stage holds no valid entry (a NOP).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush; discards all held entries and any same-cycle input.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  stage can accept an entry; registered (equals !skid_valid).
- in_ctrl_i  in  CTRL_W  upstream control bundle.
- in_data_i  in  DATA_W  upstream data bundle.
- out_valid_o  out  1  main register holds a valid entry.
- out_ready_i  in  1  downstream accepts.
- out_ctrl_o  out  CTRL_W  main control if out_valid_o, else CTRL_BUBBLE.
- out_data_o  out  DATA_W  main data; holds its last value when invalid.
- occupancy_o  out  2  held entries: 0, 1 or 2.

Behaviour:
- Definitions: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Storage: main register (drives outputs) and skid register; state encoded by valid bits as EMPTY (0 entries), ONE (main only), FULL (main + skid).
- Reset (asynchronous, immediate, also mid-operation):
  - main_valid = skid_valid = 0.
  - main/skid data = 0; main/skid ctrl = CTRL_BUBBLE.
  - Hence out_valid_o = 0, out_ctrl_o = CTRL_BUBBLE, out_data_o = 0, in_ready_o = 1, occupancy_o = 0.
- Transitions (evaluated at the clock edge when flush_i = 0):
  - EMPTY: in_fire -> ONE, main <= input. Otherwise stay.
  - ONE, in_fire & out_fire -> ONE, main <= input.
  - ONE, in_fire & !out_fire -> FULL, skid <= input, main holds.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> hold.
  - FULL: in_ready_o = 0, so no in_fire is possible.
  - FULL, out_fire -> ONE, main <= skid, skid_valid <= 0.
  - FULL, no out_fire -> hold.
- Flush (highest priority below reset):
  - Next state is EMPTY regardless of in_fire/out_fire.
  - An out_fire in the flush cycle counts as delivered; an in_fire in the flush cycle is dropped.
  - Data registers are not cleared; ctrl registers load CTRL_BUBBLE.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid_o when EMPTY.
  - Sustains 1 entry/cycle with out_ready_i held high.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush or reset.
- Output stability: while out_valid_o = 1 and out_ready_i = 0, out_ctrl_o and out_data_o are held stable.
- in_ready_o deasserts only the cycle after the skid register fills; upstream's in_fire is never lost.
- occupancy_o = main_valid + skid_valid; the value 3 is impossible.
- No combinational path from out_ready_i to in_ready_o; out_ctrl_o depends only on registered state.

Test Plan:
- Reset then idle: assert rst_i mid-cycle -> out_valid_o = 0, out_ctrl_o = CTRL_BUBBLE, in_ready_o = 1, occupancy_o = 0 immediately, without waiting for a clock edge.
- Streaming: out_ready_i = 1; drive data 0x1..0x8 on consecutive cycles -> outputs 0x1..0x8 appear one cycle later, back-to-back; occupancy_o stays 1; in_ready_o stays 1.
- Back-pressure: drive A = 0xA, B = 0xB with out_ready_i = 0 -> occupancy_o goes 1 then 2, in_ready_o = 0 after B. Release out_ready_i -> A then B delivered in order; in_ready_o returns to 1 the cycle after A leaves.
- Flush while FULL with concurrent in_fire: hold 0xA/0xB, assert flush_i with in_valid_i = 1 (in_ready_o = 0) -> next cycle occupancy_o = 0, out_ctrl_o = CTRL_BUBBLE. Repeat from ONE with in_fire = 1 -> the input is dropped.
- Reset mid-stream at FULL: assert rst_i -> both entries discarded. After deassertion, a new entry 0xC is delivered with 1-cycle latency.
- Randomised valid/ready with CTRL_W = 3, DATA_W = 16: scoreboard checks in-order, lossless delivery; checks out_data_o/out_ctrl_o stability under stall; checks in_ready_o == (occupancy_o != 2).

Source files
------------

// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_hs
// Purpose  : Generic inter-stage pipeline register carrying a control bundle
//            and a data bundle. It uses a valid/ready handshake with a 2-entry
//            skid buffer, so the upstream ready is registered and never
//            depends combinationally on the downstream ready. It also
//            supports a synchronous flush that inserts bubbles.
// Ports    : clk_i        - clock, rising edge
//            rst_i        - asynchronous active-high reset
//            flush_i      - synchronous flush (drops held and same-cycle input)
//            in_valid_i   - upstream entry valid
//            in_ready_o   - stage can accept (registered, = !skid_valid)
//            in_ctrl_i    - upstream control bundle   [CTRL_W]
//            in_data_i    - upstream data bundle      [DATA_W]
//            out_valid_o  - main register holds a valid entry
//            out_ready_i  - downstream accepts
//            out_ctrl_o   - main ctrl when valid, else CTRL_BUBBLE
//            out_data_o   - main data (holds last value when invalid)
//            occupancy_o  - number of held entries (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_hs #(
  parameter int                 DATA_W      = 64,
  parameter int                 CTRL_W      = 8,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  // The state encoding is the pair of valid bits {skid_valid, main_valid},
  // so the valid flags fall straight out of the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              main_valid;
  logic              skid_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic in_fire;
  logic out_fire;
  logic load_main_in;    // main <= upstream input
  logic load_main_skid;  // main <= skid (draining the skid buffer)
  logic load_skid_in;    // skid <= upstream input

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  // Ready comes only from the registered skid flag. This breaks the
  // out_ready -> in_ready combinational path.
  assign in_ready_o = ~skid_valid;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = main_valid & out_ready_i;

  // --------------------------------------------------------------------------
  // Next-state and register load selects
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;

    if (flush_i) begin
      // Any same-cycle input is dropped. A same-cycle output counts as
      // already delivered.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d      = ST_FULL;
            load_skid_in = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready_o is low here, so only the drain path applies.
          if (out_fire) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Payload registers. On a flush only the ctrl fields are forced to the
  // bubble value; the data fields keep their contents.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_ctrl <= CTRL_BUBBLE;
      main_data <= {DATA_W{1'b0}};
      skid_ctrl <= CTRL_BUBBLE;
      skid_data <= {DATA_W{1'b0}};
    end else if (flush_i) begin
      main_ctrl <= CTRL_BUBBLE;
      skid_ctrl <= CTRL_BUBBLE;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl_i;
        main_data <= in_data_i;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid_in) begin
        skid_ctrl <= in_ctrl_i;
        skid_data <= in_data_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid_o = main_valid;
  assign out_ctrl_o  = main_valid ? main_ctrl : CTRL_BUBBLE;
  assign out_data_o  = main_data;
  assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_hs
// Purpose  : Self-checking bench for pipe_stage_hs (CTRL_W=3, DATA_W=16,
//            non-zero bubble). A queue model holds the expected entries: an
//            entry is pushed when an input is accepted and popped when the
//            DUT delivers it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;

  localparam int          DW  = 16;
  localparam int          CW  = 3;
  localparam logic [CW-1:0] BUB = 3'b101;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int total = 0;
  int bad   = 0;

  ent_t sb[$];
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic [CW-1:0] prev_ctrl  = '0;

  pipe_stage_hs #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .CTRL_BUBBLE (BUB)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_ctrl_i   (in_ctrl),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ctrl_o  (out_ctrl),
    .out_data_o  (out_data),
    .occupancy_o (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ctrl tag derived from data, so that ctrl/data mix-ups become visible.
  function automatic logic [CW-1:0] ctl_of(input logic [DW-1:0] d);
    return d[2:0] ^ 3'b011;
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = ctl_of(d);
  endtask

  // One cycle: outputs are checked against the model (inputs already set,
  // before the edge), then the model advances and time moves to the next
  // falling edge.
  task automatic tick();
    int n;
    bit mr, inf, outf;
    ent_t e;
    n    = sb.size();
    mr   = (n < 2);
    inf  = in_valid && mr;
    outf = (n > 0) && out_ready;
    chk("occupancy", 32'(occupancy), 32'(n));
    chk("in_ready",  32'(in_ready),  32'(mr));
    chk("out_valid", 32'(out_valid), 32'(n > 0));
    if (n > 0) begin
      chk("out_data", 32'(out_data), 32'(sb[0].d));
      chk("out_ctrl", 32'(out_ctrl), 32'(sb[0].c));
    end else begin
      chk("bubble_ctrl", 32'(out_ctrl), 32'(BUB));
    end
    if (stall_prev && n > 0) begin
      chk("stable_data", 32'(out_data), 32'(prev_data));
      chk("stable_ctrl", 32'(out_ctrl), 32'(prev_ctrl));
    end
    stall_prev = (n > 0) && !out_ready && !flush;
    prev_data  = sb.size() > 0 ? sb[0].d : '0;
    prev_ctrl  = sb.size() > 0 ? sb[0].c : '0;
    if (flush) begin
      sb.delete();
    end else begin
      if (outf) void'(sb.pop_front());
      if (inf) begin
        e.c = in_ctrl;
        e.d = in_data;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset applied between edges and checked before any edge.
  task automatic mid_reset(input string tag);
    #1 rst = 1'b1;
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ctrl"},  32'(out_ctrl),  32'(BUB));
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_ready"}, 32'(in_ready),  32'd1);
    chk({tag, "_occ"},   32'(occupancy), 32'd0);
    sb.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // ---- reset then idle ------------------------------------------------
    @(negedge clk);
    mid_reset("rst0");
    out_ready = 1'b1;
    tick();
    tick();

    // ---- streaming 0x1..0x8 -------------------------------------------
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i));
      tick();
    end
    drive(1'b0, 16'h0);
    tick();
    tick();

    // ---- back-pressure -------------------------------------------------
    out_ready = 1'b0;
    drive(1'b1, 16'h000A);
    tick();
    chk("bp_occ1", 32'(occupancy), 32'd1);
    drive(1'b1, 16'h000B);
    tick();
    drive(1'b0, 16'h0);
    chk("bp_occ2",   32'(occupancy), 32'd2);
    chk("bp_ready0", 32'(in_ready),  32'd0);
    tick();
    out_ready = 1'b1;
    chk("bp_A", 32'(out_data), 32'h000A);
    tick();
    chk("bp_B",      32'(out_data), 32'h000B);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    tick();
    tick();

    // ---- flush while FULL with in_valid high ----------------------------
    out_ready = 1'b0;
    drive(1'b1, 16'h000A);
    tick();
    drive(1'b1, 16'h000B);
    tick();
    drive(1'b1, 16'h000D);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0);
    chk("fl_full_occ",  32'(occupancy), 32'd0);
    chk("fl_full_ctrl", 32'(out_ctrl),  32'(BUB));
    tick();

    // ---- flush from ONE with a concurrent in_fire ------------------------
    drive(1'b1, 16'h0011);
    tick();
    drive(1'b1, 16'h0022);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0);
    chk("fl_one_occ",   32'(occupancy), 32'd0);
    chk("fl_one_valid", 32'(out_valid), 32'd0);
    tick();

    // ---- reset mid-stream at FULL -----------------------------------------
    drive(1'b1, 16'h000A);
    tick();
    drive(1'b1, 16'h000B);
    tick();
    drive(1'b0, 16'h0);
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    mid_reset("rst1");
    out_ready = 1'b1;
    drive(1'b1, 16'h000C);
    tick();
    drive(1'b0, 16'h0);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data",  32'(out_data),  32'h000C);
    tick();
    tick();

    // ---- randomised traffic ---------------------------------------------
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom));
      in_ctrl   = 3'($urandom);
      out_ready = 1'($urandom_range(0, 2) != 0 ? (i % 64 < 40) : 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0;

    // ---- drain --------------------------------------------------------------
    drive(1'b0, 16'h0);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("drain_occ", 32'(occupancy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
